peripheral_bus_arbiter: RTL and testbench

Shares one 8-bit byte-serial peripheral bus (addr/size/read/write/start/bip/data/wait/error) between NREQ requesters. Arbitrates round-robin, then sequences a whole transfer of 1, 2 or 4 bytes as consecutive byte beats. Honours slave wait-states, aborts on slave error or wait timeout, and returns one response per accepted request. Sits between the requester ports and the peripheral bus pins that the UVM agent drives and monitors.

---
 rtl/peripheral_bus_arbiter_pkg.sv | 36 +++
 rtl/peripheral_bus_arbiter_if.sv | 49 ++++
 rtl/peripheral_bus_arbiter_rr_picker.sv | 34 +++
 rtl/peripheral_bus_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_peripheral_bus_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/peripheral_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_bus_pkg
// Description : Shared encodings, state type and helpers for the byte-serial
//               peripheral bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package peripheral_bus_pkg;

    // Transfer size encodings carried on req_size / sig_size
    localparam logic [1:0] SIZE_1B      = 2'd0;
    localparam logic [1:0] SIZE_2B      = 2'd1;
    localparam logic [1:0] SIZE_4B      = 2'd2;
    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    // Width of the per-beat wait counter; covers TIMEOUT up to 255
    localparam int TIMEOUT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Number of byte beats for a size code; illegal size yields zero beats
    function automatic logic [2:0] beat_count(input logic [1:0] size);
        case (size)
            SIZE_1B: beat_count = 3'd1;
            SIZE_2B: beat_count = 3'd2;
            SIZE_4B: beat_count = 3'd4;
            default: beat_count = 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/peripheral_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_bus_arbiter_if
// Description : Requester-side handshake and peripheral bus pins bundled for
//               the arbiter (master) and the agents around it (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface peripheral_bus_arbiter_if #(
    parameter int NREQ       = 4,
    parameter int ADDR_WIDTH = 16
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ*ADDR_WIDTH-1:0] req_addr;
    logic [NREQ*2-1:0]          req_size;
    logic [NREQ-1:0]            req_write;
    logic [NREQ*32-1:0]         req_wdata;
    logic [NREQ-1:0]            rsp_valid;
    logic [31:0]                rsp_rdata;
    logic                       rsp_error;
    logic [ADDR_WIDTH-1:0]      sig_addr;
    logic [1:0]                 sig_size;
    logic                       sig_read;
    logic                       sig_write;
    logic                       sig_start;
    logic                       sig_bip;
    logic [7:0]                 sig_data_out;
    logic                       sig_rw;
    logic [7:0]                 sig_data_in;
    logic                       sig_wait;
    logic                       sig_error;

    modport master (
        input  req_valid, req_addr, req_size, req_write, req_wdata,
        input  sig_data_in, sig_wait, sig_error,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output sig_addr, sig_size, sig_read, sig_write, sig_start, sig_bip,
        output sig_data_out, sig_rw
    );

    modport slave (
        output req_valid, req_addr, req_size, req_write, req_wdata,
        output sig_data_in, sig_wait, sig_error,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  sig_addr, sig_size, sig_read, sig_write, sig_start, sig_bip,
        input  sig_data_out, sig_rw
    );
endinterface
`default_nettype wire

// File: rtl/peripheral_bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_rr_picker
// Description : Combinational round-robin pick: first requesting index at or
//               after the pointer, wrapping, returned one-hot.
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_rr_picker #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  wire logic [NREQ-1:0]  i_req,
    input  wire logic [PTR_W-1:0] i_ptr,
    output logic      [NREQ-1:0]  o_grant,
    output logic                  o_any
);

    // Scan distances 0..NREQ-1 from the pointer; constant indices keep it flat
    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!o_any && i_req[i] &&
                    ((int'(i_ptr) + k == i) || (int'(i_ptr) + k == i + NREQ))) begin
                    o_grant[i] = 1'b1;
                    o_any      = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/peripheral_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_bus_arbiter
// Description : Round-robin arbiter that sequences 1/2/4-byte transfers as
//               byte beats on a shared peripheral bus, with wait-state
//               timeout, slave error abort and one response per request.
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_bus_arbiter
    import peripheral_bus_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  wire logic                sig_clock,
    input  wire logic                sig_reset,
    peripheral_bus_arbiter_if.master bus_if
);

    localparam int PTR_W = $clog2(NREQ);
    localparam logic [TIMEOUT_W-1:0] c_timeout_lim = TIMEOUT_W'(TIMEOUT);

    state_t                r_state,   w_state_nxt;
    logic [PTR_W-1:0]      r_ptr,     w_ptr_nxt;
    logic [PTR_W-1:0]      r_gidx,    w_gidx_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,    w_addr_nxt;
    logic [1:0]            r_size,    w_size_nxt;
    logic                  r_write,   w_write_nxt;
    logic [31:0]           r_wdata,   w_wdata_nxt;
    logic [1:0]            r_beat,    w_beat_nxt;
    logic [31:0]           r_rdata,   w_rdata_nxt;
    logic [TIMEOUT_W-1:0]  r_waitcnt, w_waitcnt_nxt;
    logic                  r_error,   w_error_nxt;
    logic                  r_first,   w_first_nxt;

    logic [NREQ-1:0]       w_pick_gnt;
    logic                  w_pick_any;
    logic [PTR_W-1:0]      w_pick_idx;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [1:0]            w_sel_size;
    logic                  w_sel_write;
    logic [31:0]           w_sel_wdata;

    peripheral_rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .i_req   (bus_if.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_gnt),
        .o_any   (w_pick_any)
    );

    // Encode the granted index and mux out that requester's fields
    always_comb begin
        w_pick_idx  = '0;
        w_sel_addr  = '0;
        w_sel_size  = '0;
        w_sel_write = 1'b0;
        w_sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick_gnt[i]) begin
                w_pick_idx  = PTR_W'(i);
                w_sel_addr  = bus_if.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_size  = bus_if.req_size[i*2 +: 2];
                w_sel_write = bus_if.req_write[i];
                w_sel_wdata = bus_if.req_wdata[i*32 +: 32];
            end
        end
    end

    // Next-state: accept in IDLE, step beats in BUS, release pointer in RESP
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_gidx_nxt    = r_gidx;
        w_addr_nxt    = r_addr;
        w_size_nxt    = r_size;
        w_write_nxt   = r_write;
        w_wdata_nxt   = r_wdata;
        w_beat_nxt    = r_beat;
        w_rdata_nxt   = r_rdata;
        w_waitcnt_nxt = r_waitcnt;
        w_error_nxt   = r_error;
        w_first_nxt   = r_first;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_gidx_nxt    = w_pick_idx;
                    w_addr_nxt    = w_sel_addr;
                    w_size_nxt    = w_sel_size;
                    w_write_nxt   = w_sel_write;
                    w_wdata_nxt   = w_sel_wdata;
                    w_beat_nxt    = '0;
                    w_rdata_nxt   = '0;
                    w_waitcnt_nxt = '0;
                    w_first_nxt   = 1'b1;
                    // Illegal size skips the bus and answers with an error
                    w_error_nxt   = (w_sel_size == SIZE_ILLEGAL);
                    w_state_nxt   = (w_sel_size == SIZE_ILLEGAL) ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                w_first_nxt = 1'b0;
                if (bus_if.sig_wait) begin
                    // A stalled beat ignores sig_error; only the timeout can end it
                    w_waitcnt_nxt = r_waitcnt + TIMEOUT_W'(1);
                    if (r_waitcnt + TIMEOUT_W'(1) == c_timeout_lim) begin
                        w_error_nxt = 1'b1;
                        w_rdata_nxt = '0;
                        w_state_nxt = ST_RESP;
                    end
                end else begin
                    w_waitcnt_nxt = '0;
                    if (bus_if.sig_error) begin
                        w_error_nxt = 1'b1;
                        w_rdata_nxt = '0;
                        w_state_nxt = ST_RESP;
                    end else begin
                        if (!r_write) begin
                            w_rdata_nxt[{r_beat, 3'b000} +: 8] = bus_if.sig_data_in;
                        end
                        w_beat_nxt = r_beat + 2'd1;
                        if (({1'b0, r_beat} + 3'd1) == beat_count(r_size)) begin
                            w_state_nxt = ST_RESP;
                        end
                    end
                end
            end
            ST_RESP: begin
                w_ptr_nxt   = (r_gidx == PTR_W'(NREQ - 1)) ? '0 : r_gidx + PTR_W'(1);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge sig_clock) begin
        if (sig_reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_gidx    <= '0;
            r_addr    <= '0;
            r_size    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_beat    <= '0;
            r_rdata   <= '0;
            r_waitcnt <= '0;
            r_error   <= 1'b0;
            r_first   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gidx    <= w_gidx_nxt;
            r_addr    <= w_addr_nxt;
            r_size    <= w_size_nxt;
            r_write   <= w_write_nxt;
            r_wdata   <= w_wdata_nxt;
            r_beat    <= w_beat_nxt;
            r_rdata   <= w_rdata_nxt;
            r_waitcnt <= w_waitcnt_nxt;
            r_error   <= w_error_nxt;
            r_first   <= w_first_nxt;
        end
    end

    // Outputs decoded from state; everything idles low outside its phase
    always_comb begin
        bus_if.req_ready    = '0;
        bus_if.rsp_valid    = '0;
        bus_if.rsp_rdata    = '0;
        bus_if.rsp_error    = 1'b0;
        bus_if.sig_addr     = '0;
        bus_if.sig_size     = '0;
        bus_if.sig_read     = 1'b0;
        bus_if.sig_write    = 1'b0;
        bus_if.sig_start    = 1'b0;
        bus_if.sig_bip      = 1'b0;
        bus_if.sig_data_out = '0;
        bus_if.sig_rw       = 1'b0;
        if (r_state == ST_IDLE && !sig_reset) begin
            bus_if.req_ready = w_pick_gnt;
        end
        if (r_state == ST_BUS) begin
            bus_if.sig_bip   = 1'b1;
            bus_if.sig_start = r_first;
            bus_if.sig_read  = ~r_write;
            bus_if.sig_write = r_write;
            bus_if.sig_rw    = r_write;
            bus_if.sig_size  = r_size;
            bus_if.sig_addr  = r_addr + ADDR_WIDTH'(r_beat);
            if (r_write) begin
                bus_if.sig_data_out = r_wdata[{r_beat, 3'b000} +: 8];
            end
        end
        if (r_state == ST_RESP) begin
            for (int i = 0; i < NREQ; i++) begin
                bus_if.rsp_valid[i] = (r_gidx == PTR_W'(i));
            end
            bus_if.rsp_rdata = r_rdata;
            bus_if.rsp_error = r_error;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_peripheral_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_peripheral_bus_arbiter
// Description : Directed self-checking bench for peripheral_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peripheral_bus_arbiter;

    logic sig_clock;
    logic sig_reset;
    int   n_checks;
    int   n_errors;

    peripheral_bus_arbiter_if #(.NREQ(4), .ADDR_WIDTH(16)) bif ();

    peripheral_bus_arbiter #(
        .NREQ       (4),
        .ADDR_WIDTH (16),
        .TIMEOUT    (4)
    ) dut (
        .sig_clock (sig_clock),
        .sig_reset (sig_reset),
        .bus_if    (bif)
    );

    initial sig_clock = 1'b0;
    always #5 sig_clock = ~sig_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sig_clock);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [15:0] a, input logic [1:0] s,
                           input logic w, input logic [31:0] d);
        bif.req_valid[idx]         = 1'b1;
        bif.req_addr[idx*16 +: 16] = a;
        bif.req_size[idx*2 +: 2]   = s;
        bif.req_write[idx]         = w;
        bif.req_wdata[idx*32 +: 32] = d;
    endtask

    task automatic clr_req(input int idx);
        bif.req_valid[idx] = 1'b0;
    endtask

    logic [15:0] e_addr [4];
    logic [7:0]  e_dat  [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        bif.req_valid   = '0;
        bif.req_addr    = '0;
        bif.req_size    = '0;
        bif.req_write   = '0;
        bif.req_wdata   = '0;
        bif.sig_data_in = '0;
        bif.sig_wait    = 1'b0;
        bif.sig_error   = 1'b0;
        sig_reset       = 1'b1;
        e_addr[0] = 16'hFFFE; e_addr[1] = 16'hFFFF; e_addr[2] = 16'h0000; e_addr[3] = 16'h0001;
        e_dat[0]  = 8'h11;    e_dat[1]  = 8'h22;    e_dat[2]  = 8'h33;    e_dat[3]  = 8'h44;

        // Reset state: outputs low, no acceptance while reset is held
        tick();
        bif.req_valid = 4'b1111;
        tick(); #1;
        chk("rst_ready", bif.req_ready, 0);
        chk("rst_bip", bif.sig_bip, 0);
        chk("rst_rsp_valid", bif.rsp_valid, 0);
        bif.req_valid = '0;
        sig_reset = 1'b0;
        tick();

        // 1-byte read from requester 0, zero wait
        tick();
        set_req(0, 16'h1234, 2'd0, 1'b0, 32'h0);
        bif.sig_data_in = 8'hA5;
        #1; chk("t1_ready", bif.req_ready, 4'b0001);
        tick(); clr_req(0); #1;
        chk("t1_start", bif.sig_start, 1);
        chk("t1_read", bif.sig_read, 1);
        chk("t1_addr", bif.sig_addr, 16'h1234);
        chk("t1_rsp_early", bif.rsp_valid, 0);
        tick(); #1;
        chk("t1_rsp_valid", bif.rsp_valid, 4'b0001);
        chk("t1_rdata", bif.rsp_rdata, 32'h000000A5);
        chk("t1_err", bif.rsp_error, 0);
        chk("t1_bip_off", bif.sig_bip, 0);

        // 4-byte write from requester 2 with address wrap
        tick();
        set_req(2, 16'hFFFE, 2'd2, 1'b1, 32'h44332211);
        #1; chk("t2_ready", bif.req_ready, 4'b0100);
        tick(); clr_req(2);
        for (int b = 0; b < 4; b++) begin
            if (b > 0) tick();
            #1;
            chk("t2_addr", bif.sig_addr, e_addr[b]);
            chk("t2_data", bif.sig_data_out, e_dat[b]);
            chk("t2_start", bif.sig_start, (b == 0) ? 1 : 0);
            chk("t2_rw", bif.sig_rw, 1);
        end
        tick(); #1;
        chk("t2_rsp_valid", bif.rsp_valid, 4'b0100);
        chk("t2_err", bif.rsp_error, 0);
        chk("t2_rdata", bif.rsp_rdata, 0);

        // 2-byte read from requester 3, three wait cycles on beat 1
        tick();
        set_req(3, 16'h0100, 2'd1, 1'b0, 32'h0);
        #1; chk("t4_ready", bif.req_ready, 4'b1000);
        tick(); clr_req(3); bif.sig_wait = 1'b0; bif.sig_data_in = 8'h5A; #1;
        chk("t4_addr0", bif.sig_addr, 16'h0100);
        tick(); bif.sig_wait = 1'b1; bif.sig_data_in = 8'hEE; #1;
        chk("t4_addr1", bif.sig_addr, 16'h0101);
        chk("t4_nostart", bif.sig_start, 0);
        tick(); bif.sig_error = 1'b1; #1;
        chk("t4_hold", bif.sig_addr, 16'h0101);
        tick(); bif.sig_error = 1'b0; #1;
        chk("t4_bip_wait", bif.sig_bip, 1);
        tick(); bif.sig_wait = 1'b0; bif.sig_data_in = 8'hC3; #1;
        chk("t4_addr_done", bif.sig_addr, 16'h0101);
        tick(); #1;
        chk("t4_rsp_valid", bif.rsp_valid, 4'b1000);
        chk("t4_rdata", bif.rsp_rdata, 32'h0000C35A);
        chk("t4_err", bif.rsp_error, 0);

        // Timeout on beat 1 of a 4-byte read from requester 1
        tick();
        set_req(1, 16'h2000, 2'd2, 1'b0, 32'h0);
        #1; chk("t5_ready", bif.req_ready, 4'b0010);
        tick(); clr_req(1); bif.sig_data_in = 8'h77; #1;
        chk("t5_start", bif.sig_start, 1);
        for (int c = 0; c < 4; c++) begin
            tick(); bif.sig_wait = 1'b1; #1;
            chk("t5_stall_bip", bif.sig_bip, 1);
        end
        tick(); bif.sig_wait = 1'b0; #1;
        chk("t5_rsp_valid", bif.rsp_valid, 4'b0010);
        chk("t5_err", bif.rsp_error, 1);
        chk("t5_rdata", bif.rsp_rdata, 0);
        chk("t5_bip_off", bif.sig_bip, 0);

        // Slave error on beat 0 of a 4-byte write from requester 2
        tick();
        set_req(2, 16'h3000, 2'd2, 1'b1, 32'hDDCCBBAA);
        #1; chk("t6_ready", bif.req_ready, 4'b0100);
        tick(); clr_req(2); bif.sig_error = 1'b1; #1;
        chk("t6_data", bif.sig_data_out, 8'hAA);
        chk("t6_write", bif.sig_write, 1);
        tick(); bif.sig_error = 1'b0; #1;
        chk("t6_rsp_valid", bif.rsp_valid, 4'b0100);
        chk("t6_err", bif.rsp_error, 1);
        chk("t6_bip_off", bif.sig_bip, 0);

        // Illegal size from requester 0; pointer wraps from 3 to 0
        tick();
        set_req(0, 16'h5000, 2'd3, 1'b0, 32'h0);
        #1; chk("t7_ready", bif.req_ready, 4'b0001);
        tick(); clr_req(0); #1;
        chk("t7_bip", bif.sig_bip, 0);
        chk("t7_rsp_valid", bif.rsp_valid, 4'b0001);
        chk("t7_err", bif.rsp_error, 1);

        // Reset during beat 1 of a 2-byte read from requester 1
        tick();
        set_req(1, 16'h4000, 2'd1, 1'b0, 32'h0);
        #1; chk("t8_ready", bif.req_ready, 4'b0010);
        tick(); clr_req(1); bif.sig_data_in = 8'h11; #1;
        chk("t8_start", bif.sig_start, 1);
        tick(); sig_reset = 1'b1; #1;
        chk("t8_addr1", bif.sig_addr, 16'h4001);
        tick(); sig_reset = 1'b0; #1;
        chk("t8_bip_off", bif.sig_bip, 0);
        chk("t8_addr_off", bif.sig_addr, 0);
        chk("t8_read_off", bif.sig_read, 0);
        chk("t8_no_rsp", bif.rsp_valid, 0);
        tick(); #1;
        chk("t8_no_rsp_late", bif.rsp_valid, 0);

        // All requesters valid: grants rotate 0,1,2,3,0 from a reset pointer
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 16'h6000 + 16'(i), 2'd0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            #1; chk("t9_ready", bif.req_ready, 32'(1 << (k % 4)));
            tick(); bif.sig_data_in = 8'(8'h30 + k); #1;
            chk("t9_ready_busy", bif.req_ready, 0);
            tick(); #1;
            chk("t9_rsp_valid", bif.rsp_valid, 32'(1 << (k % 4)));
            chk("t9_rdata", bif.rsp_rdata, 32'(8'h30 + k));
        end
        bif.req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
